alu_acc_seq: RTL and testbench
==============================

# alu_acc_seq

Accumulator sequencer that sits directly upstream of the 4-bit combinational ALU and drives its A/B/func inputs. It accepts one command at a time over a valid/ready handshake, presents `acc` and the command operand to the ALU, and waits a programmable settle time. It then captures the ALU result and carry/overflow back into a 4-bit accumulator with Z/N/C/V flags. This turns the switch-driven ALU into a sequential accumulator machine; `acc` feeds the 7-segment path downstream.

## Interface
- `SETTLE_CYCLES`, default 1: cycles the ALU inputs are held before capture; legal range 1–15.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  command valid.
- `in_ready`  out  1  sequencer can accept a command.
- `in_load`  in  1  1 = LOAD (`acc <= in_data`, ALU bypassed); 0 = ALU op.
- `in_op`  in  3  ALU function: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 pass; 110/111 behave as pass.
- `in_data`  in  4  operand (ALU B, or LOAD value).
- `alu_a`  out  4  to ALU A (registered copy of `acc`).
- `alu_b`  out  4  to ALU B (registered `in_data`).
- `alu_func`  out  3  to ALU func (registered `in_op`).
- `alu_y`  in  4  ALU result.
- `alu_c`  in  1  ALU carry-out (sub: 1 = no borrow).
- `alu_v`  in  1  ALU signed overflow.
- `acc`  out  4  accumulator.
- `flags`  out  4  {Z, N, C, V}.
- `out_valid`  out  1  one-cycle pulse: `acc`/`flags` just updated.
- `op_count`  out  8  committed-command counter, wraps 255→0.

## Operation
- States: IDLE, ISSUE, DONE.
- Handshake: accept on the rising edge where `in_valid & in_ready`. `in_ready = (state==IDLE) & ~reset`. Unaccepted commands are ignored; there is no queue.
- IDLE + accept, ALU op: latch `alu_a<=acc`, `alu_b<=in_data`, `alu_func<=in_op`, and the op class; clear the settle counter; go to ISSUE.
- ISSUE: hold the ALU inputs; increment the counter each cycle. On the edge where counter == `SETTLE_CYCLES-1`, commit and go to DONE.
- ALU commit:
  - `acc<=alu_y`; Z=(alu_y==0); N=alu_y[3].
  - add/sub: C=`alu_c`, V=`alu_v`.
  - and/or/xor/pass/110/111: C=0, V=0.
- IDLE + accept, LOAD: commit immediately (`acc<=in_data`, Z/N from data, C=V=0); go to DONE. `alu_*` are unchanged.
- DONE: `out_valid=1` for exactly this cycle, `in_ready=0`; next state IDLE.
- `op_count` increments by 1 on every commit (LOAD and ALU), modulo 256.
- `alu_a/alu_b/alu_func` change only on ALU-op acceptance and otherwise hold their last values.
- `in_data`/`in_op` changes after acceptance have no effect on the command in flight.

## Timing
- Reset (sync, edge-sampled):
  - state=IDLE, `acc`=0, `flags`=4'b1000 (Z consistent with acc=0).
  - `alu_a/alu_b/alu_func`=0, `out_valid`=0, `op_count`=0.
  - `in_ready`=0 while `reset` is high and 1 in the first cycle after release.
- Reset mid-operation (ISSUE or DONE): the command is aborted, all registers take reset values, no `out_valid`, `op_count` is not incremented.
- Latency, accept edge = edge 0:
  - ALU op: ALU inputs stable from cycle 1 through cycle `SETTLE_CYCLES`; commit at edge `SETTLE_CYCLES`; `out_valid` in cycle `SETTLE_CYCLES+1`; `in_ready` again in cycle `SETTLE_CYCLES+2`.
  - LOAD: commit at edge 0; `out_valid` in cycle 1; `in_ready` in cycle 2.
- Throughput with `in_valid` held high: one ALU op per `SETTLE_CYCLES+2` cycles; one LOAD per 2 cycles.
- The ALU is combinational, so `SETTLE_CYCLES`=1 suffices; larger values cover a registered or slow ALU path.

## Test plan
- Reset: 2 cycles high with `in_valid`=1 → no acceptance; after release `acc`=0, `flags`=1000, `op_count`=0, `out_valid`=0, `in_ready`=1.
- LOAD 0x7 then ADD 0x1 (ALU model attached, SETTLE=1) → `alu_a`=7, `alu_b`=1, `alu_func`=000 in cycle 1; `out_valid` in cycle 2; `acc`=0x8, `flags`=0101; `op_count`=2.
- LOAD 0x3, SUB 0x3 → `acc`=0, `flags`=1010. Then LOAD 0xA, AND 0xC → `acc`=0x8, `flags`=0100 (C/V cleared).
- `in_valid` held high with new data every cycle, SETTLE=1 → acceptances exactly 3 cycles apart; intermediate data ignored. Run 257 commits → `op_count` wraps to 1.
- SETTLE_CYCLES=3: accept at edge 0 → ALU inputs held cycles 1–3; `out_valid` only in cycle 4. A LOAD still yields `out_valid` in cycle 1.
- Assert `reset` for one cycle during ISSUE after LOAD 0x5 + ADD → no `out_valid`; `acc`=0, `flags`=1000, `op_count`=0; next command is accepted normally.

Source files
------------

// File: rtl/alu_acc_seq.sv
// Accumulator sequencer driving a 4-bit combinational ALU.
// Holds ALU inputs for a settle window, then captures result and flags.
module alu_acc_seq #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_load,
  input  logic [2:0] in_op,
  input  logic [3:0] in_data,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_func,
  input  logic [3:0] alu_y,
  input  logic       alu_c,
  input  logic       alu_v,
  output logic [3:0] acc,
  output logic [3:0] flags,
  output logic       out_valid,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_e;

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] flags_q, flags_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [2:0] alu_func_q, alu_func_d;
  logic       arith_q, arith_d;
  logic [7:0] op_count_q, op_count_d;
  logic       accept;

  assign in_ready  = (state_q == IDLE) & ~reset;
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;

  assign acc      = acc_q;
  assign flags    = flags_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_func = alu_func_q;
  assign op_count = op_count_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    flags_d    = flags_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_func_d = alu_func_q;
    arith_d    = arith_q;
    op_count_d = op_count_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_load) begin
            acc_d      = in_data;
            flags_d    = {in_data == 4'd0, in_data[3], 2'b00};
            op_count_d = op_count_q + 8'd1;
            state_d    = DONE;
          end else begin
            alu_a_d    = acc_q;
            alu_b_d    = in_data;
            alu_func_d = in_op;
            // only add/sub report carry and overflow
            arith_d    = (in_op == 3'b000) | (in_op == 3'b001);
            cnt_d      = 4'd0;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == LAST) begin
          acc_d      = alu_y;
          flags_d    = {alu_y == 4'd0, alu_y[3],
                        arith_q & alu_c, arith_q & alu_v};
          op_count_d = op_count_q + 8'd1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      acc_q      <= 4'd0;
      flags_q    <= 4'b1000;
      alu_a_q    <= 4'd0;
      alu_b_q    <= 4'd0;
      alu_func_q <= 3'd0;
      arith_q    <= 1'b0;
      op_count_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      flags_q    <= flags_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_func_q <= alu_func_d;
      arith_q    <= arith_d;
      op_count_q <= op_count_d;
    end
  end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Scoreboard bench for alu_acc_seq with an attached ALU model.
// Second instance covers a longer settle window.
module tb_alu_acc_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, v3;
  logic       in_load;
  logic [2:0] in_op;
  logic [3:0] in_data;
  logic       in_ready, r3_ready;
  logic [3:0] alu_a, alu_b, a3, b3;
  logic [2:0] alu_func, f3;
  logic [3:0] alu_y, y3;
  logic       alu_c, alu_v, c3, ov3;
  logic [3:0] acc, flags, acc3, flags3;
  logic       out_valid, ov_3;
  logic [7:0] op_count, cnt3;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  // adder carry/overflow leak out on logic ops, as in a ripple-adder ALU
  function automatic logic [5:0] alu_model(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic [2:0] f);
    logic [4:0] s;
    logic [3:0] y;
    logic       c, v;
    s = {1'b0, a} + {1'b0, b};
    c = s[4];
    v = (a[3] == b[3]) && (s[3] != a[3]);
    case (f)
      3'b000: y = s[3:0];
      3'b001: begin
        s = {1'b0, a} - {1'b0, b};
        y = s[3:0];
        c = ~s[4];
        v = (a[3] != b[3]) && (y[3] != a[3]);
      end
      3'b010: y = a & b;
      3'b011: y = a | b;
      3'b100: y = a ^ b;
      default: y = b;
    endcase
    return {y, c, v};
  endfunction

  assign {alu_y, alu_c, alu_v} = alu_model(alu_a, alu_b, alu_func);
  assign {y3, c3, ov3}         = alu_model(a3, b3, f3);

  alu_acc_seq #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_op(in_op), .in_data(in_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_y(alu_y), .alu_c(alu_c), .alu_v(alu_v),
    .acc(acc), .flags(flags),
    .out_valid(out_valid), .op_count(op_count)
  );

  alu_acc_seq #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .in_valid(v3), .in_ready(r3_ready),
    .in_load(in_load), .in_op(in_op), .in_data(in_data),
    .alu_a(a3), .alu_b(b3), .alu_func(f3),
    .alu_y(y3), .alu_c(c3), .alu_v(ov3),
    .acc(acc3), .flags(flags3),
    .out_valid(ov_3), .op_count(cnt3)
  );

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got acc=%h flags=%b cnt=%0d", acc,
                 flags, op_count);
      end else begin
        chk("sb_result", {acc, flags, op_count}, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic ld, input logic [2:0] op,
                      input logic [3:0] d);
    in_load  = ld;
    in_op    = op;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    if (!in_ready) chk("send_timeout", 16'd0, 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    if (!in_ready) chk("idle_timeout", 16'd0, 16'd1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    v3       = 1'b0;
    in_load  = 1'b1;
    in_data  = 4'hF;
    in_op    = 3'd0;
    @(negedge clk);
    chk("rst_ready", {15'd0, in_ready}, 16'd0);
    @(negedge clk);
    chk("rst_ready2", {15'd0, in_ready}, 16'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_state", {acc, flags, op_count}, {4'h0, 4'b1000, 8'd0});
    chk("rst_ov_rdy", {14'd0, out_valid, in_ready}, 16'd1);
  endtask

  initial begin
    logic [3:0] macc;
    logic [7:0] mcnt;
    logic [5:0] r;
    int         last, naccept;

    do_reset();

    // LOAD 7 then ADD 1
    exp_q.push_back({4'h7, 4'b0000, 8'd1});
    send(1'b1, 3'd0, 4'h7);
    wait_idle();
    exp_q.push_back({4'h8, 4'b0101, 8'd2});
    send(1'b0, 3'b000, 4'h1);
    in_data = 4'hB;
    chk("c1_alu_in", {5'd0, alu_a, alu_b, alu_func},
        {5'd0, 4'h7, 4'h1, 3'b000});
    chk("c1_no_ov", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    chk("c2_ov", {15'd0, out_valid}, 16'd1);
    chk("c2_rdy", {15'd0, in_ready}, 16'd0);
    @(negedge clk);
    chk("c3_rdy", {15'd0, in_ready}, 16'd1);

    // SUB to zero, then AND clears C/V
    exp_q.push_back({4'h3, 4'b0000, 8'd3});
    send(1'b1, 3'd0, 4'h3);
    wait_idle();
    exp_q.push_back({4'h0, 4'b1010, 8'd4});
    send(1'b0, 3'b001, 4'h3);
    wait_idle();
    exp_q.push_back({4'hA, 4'b0100, 8'd5});
    send(1'b1, 3'd0, 4'hA);
    wait_idle();
    exp_q.push_back({4'h8, 4'b0100, 8'd6});
    send(1'b0, 3'b010, 4'hC);
    wait_idle();
    chk("load_keeps_alu", {8'd0, alu_a, alu_b}, {8'd0, 4'hA, 4'hC});

    // back-to-back ADDs with new data every cycle, 257 commits
    do_reset();
    macc     = 4'h0;
    mcnt     = 8'd0;
    last     = 0;
    naccept  = 0;
    in_load  = 1'b0;
    in_op    = 3'b000;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 2000 && naccept < 257; cyc++) begin
      in_data = 4'(cyc * 5 + 3);
      if (in_ready) begin
        r    = alu_model(macc, in_data, 3'b000);
        macc = r[5:2];
        mcnt = mcnt + 8'd1;
        exp_q.push_back({macc, macc == 4'd0, macc[3], r[1], r[0], mcnt});
        if (naccept > 0) chk("spacing", 16'(cyc - last), 16'd3);
        last = cyc;
        naccept++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("n_accept", 16'(naccept), 16'd257);
    wait_idle();
    chk("wrap_cnt", {8'd0, op_count}, 16'd1);

    // SETTLE_CYCLES=3 instance
    do_reset();
    in_load = 1'b0;
    in_op   = 3'b000;
    in_data = 4'h5;
    v3      = 1'b1;
    chk("s3_rdy0", {15'd0, r3_ready}, 16'd1);
    @(negedge clk);
    v3      = 1'b0;
    in_data = 4'h9;
    in_op   = 3'b100;
    for (int k = 1; k <= 3; k++) begin
      chk("s3_hold", {5'd0, a3, b3, f3}, {5'd0, 4'h0, 4'h5, 3'b000});
      chk("s3_no_ov", {15'd0, ov_3}, 16'd0);
      @(negedge clk);
    end
    chk("s3_ov", {15'd0, ov_3}, 16'd1);
    chk("s3_res", {acc3, flags3, cnt3}, {4'h5, 4'b0000, 8'd1});
    @(negedge clk);
    chk("s3_rdy", {15'd0, r3_ready}, 16'd1);
    in_load = 1'b1;
    in_data = 4'hE;
    v3      = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    chk("s3_ld_ov", {15'd0, ov_3}, 16'd1);
    chk("s3_ld_res", {acc3, flags3, cnt3}, {4'hE, 4'b0100, 8'd2});
    chk("s3_ld_alu", {12'd0, b3}, 16'h5);

    // reset during ISSUE aborts the command
    exp_q.push_back({4'h5, 4'b0000, 8'd1});
    send(1'b1, 3'd0, 4'h5);
    wait_idle();
    send(1'b0, 3'b000, 4'h2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_state", {acc, flags, op_count}, {4'h0, 4'b1000, 8'd0});
    chk("abort_ov_rdy", {14'd0, out_valid, in_ready}, 16'd1);
    @(negedge clk);
    chk("abort_no_ov", {15'd0, out_valid}, 16'd0);
    exp_q.push_back({4'h3, 4'b0000, 8'd1});
    send(1'b0, 3'b000, 4'h3);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
